// File: rtl/instr_byte_assembler_pkg.sv
// Shared types and constants for the instruction byte assembler block.
package instr_byte_assembler_pkg;

  localparam int INSTR_W            = 16;
  localparam int BYTE_W             = 8;
  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int TIMER_W            = 16;

  typedef enum logic {
    ST_WAIT_LO = 1'b0,
    ST_WAIT_HI = 1'b1
  } byte_state_e;

endpackage

// File: rtl/instr_byte_assembler_if.sv
// Instruction handshake between the assembler (master) and the compute-unit pair (slave).
interface instr_byte_assembler_if;
  import instr_byte_assembler_pkg::*;

  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic               instr_ready;

  modport master (output instr_out, output instr_valid, input instr_ready);
  modport slave  (input instr_out, input instr_valid, output instr_ready);

endinterface

// File: rtl/instr_byte_assembler_sync_fifo.sv
// Synchronous FIFO with registered head data, valid, full and count; a push may
// land on a full FIFO only when a pop happens in the same cycle.
module sync_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d, full_q, full_d;
  logic             push_ok_s, pop_ok_s;

  // Pointer/count update and next head; a head slot written this cycle is forwarded from din_i.
  always_comb begin
    pop_ok_s  = pop_i & valid_q;
    push_ok_s = push_i & (~full_q | pop_ok_s);
    wr_ptr_d  = push_ok_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop_ok_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != CNT_W'(0));
    full_d  = (count_d == CNT_W'(DEPTH));
    if (count_d == CNT_W'(0)) begin
      dout_d = '0;
    end else if (push_ok_s && (rd_ptr_d == wr_ptr_q)) begin
      dout_d = din_i;
    end else begin
      dout_d = mem_q[rd_ptr_d];
    end
  end

  // Storage and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      if (push_ok_s) mem_q[wr_ptr_q] <= din_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
    end
  end

  assign dout_o  = dout_q;
  assign valid_o = valid_q;
  assign full_o  = full_q;
  assign count_o = count_q;

endmodule

// File: rtl/instr_byte_assembler.sv
// Assembles 16-bit instructions from strobed pin bytes (low first) into a FIFO.
// Optional half-instruction timeout is enabled with `define CMD_TIMEOUT_EN.
module instr_byte_assembler
  import instr_byte_assembler_pkg::*;
#(
  parameter  int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int CNT_W          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [BYTE_W-1:0]     byte_in,
  input  logic                  byte_strobe,
  instr_byte_assembler_if.master instr_bus,
  output logic [CNT_W-1:0]      fifo_count,
  output logic                  half_pending,
  output logic                  overflow,
  output logic                  timeout_err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 || FIFO_DEPTH < 2) begin : g_cfg_out_of_range
  end

  logic              strb_meta_q, strb_sync_q, strb_prev_q;
  logic              edge_s, expire_s, push_s, pop_s, drop_s, full_s, valid_s;
  byte_state_e       state_q, state_d;
  logic [BYTE_W-1:0] lo_q, lo_d;
  logic              overflow_q, overflow_d;

  // Strobe synchroniser and edge history; samples even while ena is low so frozen edges are lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      strb_meta_q <= 1'b0;
      strb_sync_q <= 1'b0;
      strb_prev_q <= 1'b0;
    end else begin
      strb_meta_q <= byte_strobe;
      strb_sync_q <= strb_meta_q;
      strb_prev_q <= strb_sync_q;
    end
  end

  assign edge_s = strb_sync_q & ~strb_prev_q;
  assign pop_s  = ena & valid_s & instr_bus.instr_ready;
  assign drop_s = push_s & full_s & ~pop_s;

  // Byte FSM next state, push request and sticky overflow.
  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    push_s     = 1'b0;
    overflow_d = overflow_q | drop_s;
    if (ena) begin
      case (state_q)
        ST_WAIT_LO: begin
          if (edge_s) begin
            lo_d    = byte_in;
            state_d = ST_WAIT_HI;
          end else begin
            state_d = ST_WAIT_LO;
          end
        end
        ST_WAIT_HI: begin
          if (edge_s) begin
            push_s  = 1'b1;
            state_d = ST_WAIT_LO;
          end else if (expire_s) begin
            lo_d    = '0;
            state_d = ST_WAIT_LO;
          end else begin
            state_d = ST_WAIT_HI;
          end
        end
        default: state_d = ST_WAIT_LO;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Byte FSM state, held low byte and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_WAIT_LO;
      lo_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef CMD_TIMEOUT_EN
  logic [TIMER_W-1:0] to_cnt_q, to_cnt_d;
  logic               to_err_q, to_err_d;

  // Timeout counter; an edge in the expiry cycle wins over the timeout.
  always_comb begin
    to_cnt_d = to_cnt_q;
    to_err_d = to_err_q;
    expire_s = 1'b0;
    if (state_q == ST_WAIT_LO) begin
      to_cnt_d = '0;
    end else if (ena) begin
      if (edge_s) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
        expire_s = 1'b1;
        to_err_d = 1'b1;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + TIMER_W'(1);
      end
    end else begin
      to_cnt_d = to_cnt_q;
    end
  end

  // Timeout counter and sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  end

  assign timeout_err = to_err_q;
`else
  assign expire_s    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .din_i   ({byte_in, lo_q}),
    .dout_o  (instr_bus.instr_out),
    .valid_o (valid_s),
    .full_o  (full_s),
    .count_o (fifo_count)
  );

  assign instr_bus.instr_valid = valid_s;
  assign half_pending          = (state_q == ST_WAIT_HI);
  assign overflow              = overflow_q;

endmodule

// File: tb/tb_instr_byte_assembler.sv
// Directed, table-driven bench for instr_byte_assembler (FIFO_DEPTH=4, TIMEOUT_CYCLES=10).
module tb_instr_byte_assembler;

  logic       clk = 1'b0;
  logic       rst, ena, byte_strobe;
  logic [7:0] byte_in;
  logic [2:0] fifo_count;
  logic       half_pending, overflow, timeout_err;
  int         total = 0;
  int         bad   = 0;

  instr_byte_assembler_if bus ();

  always #5 clk = ~clk;

  instr_byte_assembler #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .byte_in      (byte_in),
    .byte_strobe  (byte_strobe),
    .instr_bus    (bus),
    .fifo_count   (fifo_count),
    .half_pending (half_pending),
    .overflow     (overflow),
    .timeout_err  (timeout_err)
  );

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs [5];
  logic [15:0] exp3 [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in     = b;
    byte_strobe = 1'b1;
    repeat (4) @(negedge clk);
    byte_strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pop_one();
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{lo: 8'h34, hi: 8'h12, exp: 16'h1234};
    vecs[1] = '{lo: 8'hEF, hi: 8'hBE, exp: 16'hBEEF};
    vecs[2] = '{lo: 8'h00, hi: 8'h00, exp: 16'h0000};
    vecs[3] = '{lo: 8'hFF, hi: 8'hFF, exp: 16'hFFFF};
    vecs[4] = '{lo: 8'hA5, hi: 8'h5A, exp: 16'h5AA5};
    exp3[0] = 16'h0022; exp3[1] = 16'h0033; exp3[2] = 16'h0044; exp3[3] = 16'h00AA;

    rst = 1'b1; ena = 1'b1; byte_strobe = 1'b0; byte_in = 8'h00; bus.instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_instr_out", 32'(bus.instr_out), 32'h0);
    chk("rst_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst_count", 32'(fifo_count), 32'h0);
    chk("rst_half", 32'(half_pending), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_timeout", 32'(timeout_err), 32'h0);

    // Latency of capture/push around the high byte.
    send_byte(8'h34);
    chk("t1_half_after_lo", 32'(half_pending), 32'h1);
    byte_in = 8'h12; byte_strobe = 1'b1;
    repeat (2) @(negedge clk);
    chk("t1_valid_before_capture", 32'(bus.instr_valid), 32'h0);
    @(negedge clk);
    chk("t1_valid_after_capture", 32'(bus.instr_valid), 32'h1);
    chk("t1_instr", 32'(bus.instr_out), 32'h1234);
    chk("t1_count", 32'(fifo_count), 32'h1);
    chk("t1_half_after_hi", 32'(half_pending), 32'h0);
    @(negedge clk);
    byte_strobe = 1'b0;
    repeat (4) @(negedge clk);
    pop_one();
    chk("t1_count_after_pop", 32'(fifo_count), 32'h0);

    for (int i = 0; i < 5; i++) begin
      send_byte(vecs[i].lo);
      send_byte(vecs[i].hi);
      chk($sformatf("vec%0d_instr", i), 32'(bus.instr_out), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_valid", i), 32'(bus.instr_valid), 32'h1);
      chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'h1);
      pop_one();
      chk($sformatf("vec%0d_empty", i), 32'(bus.instr_valid), 32'h0);
    end

    // Overflow: fifth word dropped.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      send_byte(8'(i));
      send_byte(8'h00);
    end
    chk("t2_count_full", 32'(fifo_count), 32'h4);
    chk("t2_overflow", 32'(overflow), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t2_pop%0d", i), 32'(bus.instr_out), 32'(i));
      pop_one();
    end
    chk("t2_valid_drained", 32'(bus.instr_valid), 32'h0);
    chk("t2_overflow_sticky", 32'(overflow), 32'h1);

    // Push into a full FIFO in the same cycle as a pop.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      send_byte(8'(i * 17));
      send_byte(8'h00);
    end
    chk("t3_count_full", 32'(fifo_count), 32'h4);
    send_byte(8'hAA);
    byte_in = 8'h00; byte_strobe = 1'b1;
    repeat (2) @(negedge clk);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    chk("t3_count_same", 32'(fifo_count), 32'h4);
    chk("t3_no_overflow", 32'(overflow), 32'h0);
    byte_strobe = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_drain%0d", i), 32'(bus.instr_out), 32'(exp3[i]));
      pop_one();
    end
    chk("t3_empty", 32'(fifo_count), 32'h0);

    // Reset in the middle of an instruction.
    do_reset();
    send_byte(8'h55);
    chk("t4_half_before_rst", 32'(half_pending), 32'h1);
    do_reset();
    chk("t4_half_after_rst", 32'(half_pending), 32'h0);
    send_byte(8'h11);
    send_byte(8'h22);
    chk("t4_instr", 32'(bus.instr_out), 32'h2211);
    chk("t4_count", 32'(fifo_count), 32'h1);

    // Strobes while disabled are lost.
    do_reset();
    ena = 1'b0;
    send_byte(8'hEF);
    send_byte(8'hBE);
    chk("t6_count_disabled", 32'(fifo_count), 32'h0);
    chk("t6_half_disabled", 32'(half_pending), 32'h0);
    ena = 1'b1;
    send_byte(8'hEF);
    send_byte(8'hBE);
    chk("t6_instr", 32'(bus.instr_out), 32'hBEEF);
    chk("t6_count", 32'(fifo_count), 32'h1);

    // Long gap between low and high byte.
    do_reset();
    send_byte(8'h77);
    repeat (12) @(negedge clk);
`ifdef CMD_TIMEOUT_EN
    chk("t5_timeout_err", 32'(timeout_err), 32'h1);
    chk("t5_half_cleared", 32'(half_pending), 32'h0);
    send_byte(8'h01);
    send_byte(8'h02);
    chk("t5_instr", 32'(bus.instr_out), 32'h0201);
    chk("t5_count", 32'(fifo_count), 32'h1);
    chk("t5_timeout_sticky", 32'(timeout_err), 32'h1);
`else
    chk("t5_no_timeout", 32'(timeout_err), 32'h0);
    chk("t5_half_held", 32'(half_pending), 32'h1);
    send_byte(8'h01);
    chk("t5_instr", 32'(bus.instr_out), 32'h0177);
    chk("t5_count", 32'(fifo_count), 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
